seq_decorr: RTL and testbench
=============================

SEQ_DECORR -- requirements
Module: seq_decorr

Interface
REQ-001: Parameter DEPTH, default 4, number of shuffle-buffer entries per stream; SHALL be a power of 2 in the range 2..16.
REQ-002: Parameter LFSR_W, default 8, width of each index-generating LFSR; fixed at 8 in this revision.
REQ-003: clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: en  input  1  advance enable; when 0, all state holds.
REQ-006: x  input  1  stochastic bitstream X, one bit per cycle.
REQ-007: y  input  1  stochastic bitstream Y, one bit per cycle, typically correlated with X.
REQ-008: x_dec_r  output  1  registered, decorrelated X stream.
REQ-009: y_dec_r  output  1  registered, decorrelated Y stream.

Function
REQ-010: The block SHALL hold two independent DEPTH-entry 1-bit shuffle buffers, bufx and bufy, plus two 8-bit LFSRs, lfx and lfy.
REQ-011: Both LFSRs SHALL be Fibonacci, shift-left, with new bit0 = b7^b5^b4^b3 (x^8+x^6+x^5+x^4+1), giving a maximal period of 255.
REQ-012: Each LFSR SHALL drive a read/write index idx = LFSR[log2(DEPTH)-1:0].
REQ-013: On a rising edge with rst_n=1 and en=1, the X path SHALL perform all of the following in the same cycle.
- x_dec_r <= bufx[idx_x], using the old contents.
- bufx[idx_x] <= x.
- lfx advances one step.
REQ-014: The Y path SHALL behave identically using bufy, idx_y and lfy.
REQ-015: Read-before-write SHALL apply at the same index: an input bit never appears on the output in the cycle it is accepted; minimum latency is 1 edge, maximum is unbounded but statistically ~DEPTH.
REQ-016: With en=0, buffers, LFSRs and outputs SHALL hold their values.
REQ-017: The block SHALL conserve ones: over any interval, ones emitted = ones accepted + ones in the buffer at start - ones in the buffer at end.
REQ-018: The X and Y paths SHALL share no state; decorrelation comes from distinct LFSR seeds.
REQ-019: The block SHALL contain no combinational path from x, y or en to x_dec_r or y_dec_r.

Reset
REQ-020: While rst_n=0, the block SHALL hold the following values, taking effect immediately without waiting for a clock edge.
- x_dec_r = 0 and y_dec_r = 0.
- lfx = 8'hA5 and lfy = 8'h3C.
- Buffer entry i = 1 for odd i and 0 for even i (DEPTH=4 gives entries [3:0] = 1010), so each buffer holds DEPTH/2 ones.
REQ-021: Reset asserted mid-stream SHALL discard all buffered bits and restore every REQ-020 value; the first post-reset edge with en=1 SHALL use idx_x = 5 mod DEPTH and idx_y = 12 mod DEPTH.
REQ-022: Deassertion of rst_n SHALL be safe when it coincides with en=1; the first state update occurs at the first rising edge after deassertion.

Verification
REQ-023: The bench SHALL drive x, y and en at the falling edge and check outputs at the next falling edge, covering at least the scenarios below with DEPTH=4.
REQ-024: Reset scenario: assert rst_n=0 mid-stream, between edges -> x_dec_r=y_dec_r=0 immediately; first enabled edge outputs bufx[1]=1 and bufy[0]=0.
REQ-025: Stall scenario: hold en=0 for 10 cycles with toggling x and y -> outputs and internal state unchanged; resuming yields the same sequence as an uninterrupted run.
REQ-026: All-ones scenario: apply x=y=1 for 256 cycles from reset -> exactly 254 ones on each output, and both buffers end all ones.
REQ-027: All-zeros scenario: apply x=y=0 for 256 cycles from reset -> exactly 2 ones on each output, and both buffers end all zeros.
REQ-028: Identical-input scenario: apply x=y, a 256-bit stream with 128 ones -> per-output ones counts satisfy REQ-017 exactly; |SCC(x_dec_r, y_dec_r)| < 0.3, versus input SCC = 1.
REQ-029: Reference-model scenario: run random x and y at p=0.25 and p=0.75 for 1024 cycles, with random en and one mid-run reset -> cycle-exact match against a bit-accurate model of REQ-011 to REQ-021.

Source files
------------

// File: rtl/seq_decorr_if.sv
// Bitstream bundle for seq_decorr: advance enable, the two input streams and
// the two registered decorrelated outputs.
interface seq_decorr_if;
  logic en;
  logic x;
  logic y;
  logic x_dec_r;
  logic y_dec_r;

  modport master (
    output en, x, y,
    input  x_dec_r, y_dec_r
  );

  modport slave (
    input  en, x, y,
    output x_dec_r, y_dec_r
  );
endinterface

// File: rtl/seq_decorr.sv
// Stochastic-bitstream decorrelator: each stream passes through its own
// LFSR-addressed shuffle buffer (read old bit, write new bit, same slot).
module seq_decorr #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LFSR_W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_decorr_if.slave  bus
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [LFSR_W-1:0] SEED_X = LFSR_W'(8'hA5);
  localparam logic [LFSR_W-1:0] SEED_Y = LFSR_W'(8'h3C);

  // Odd slots hold 1 so each buffer starts with DEPTH/2 ones.
  function automatic logic [DEPTH-1:0] buf_init();
    logic [DEPTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      p[i] = i[0];
    end
    return p;
  endfunction

  localparam logic [DEPTH-1:0] BUF_INIT = buf_init();

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [DEPTH-1:0]  bufx, bufy;
  logic [LFSR_W-1:0] lfx, lfy;
  logic [IW-1:0]     idx_x, idx_y;
  logic              x_dec_q, y_dec_q;

  assign idx_x = lfx[IW-1:0];
  assign idx_y = lfy[IW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufx    <= BUF_INIT;
      lfx     <= SEED_X;
      x_dec_q <= 1'b0;
    end else if (bus.en) begin
      x_dec_q     <= bufx[idx_x];
      bufx[idx_x] <= bus.x;
      lfx         <= lfsr_next(lfx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufy    <= BUF_INIT;
      lfy     <= SEED_Y;
      y_dec_q <= 1'b0;
    end else if (bus.en) begin
      y_dec_q     <= bufy[idx_y];
      bufy[idx_y] <= bus.y;
      lfy         <= lfsr_next(lfy);
    end
  end

  assign bus.x_dec_r = x_dec_q;
  assign bus.y_dec_r = y_dec_q;

endmodule

// File: tb/tb_seq_decorr.sv
// Directed and model-checked bench for seq_decorr with DEPTH=4.
module tb_seq_decorr;
  localparam int unsigned D = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   ox_ones, oy_ones;

  seq_decorr_if bus ();

  seq_decorr #(.DEPTH(D), .LFSR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model, written from the behavioural description.
  logic [7:0] m_lfx, m_lfy;
  bit         m_bx[D];
  bit         m_by[D];
  bit         m_ox, m_oy;

  task automatic model_reset();
    m_lfx = 8'hA5;
    m_lfy = 8'h3C;
    for (int i = 0; i < D; i++) begin
      m_bx[i] = (i % 2 == 1);
      m_by[i] = (i % 2 == 1);
    end
    m_ox = 1'b0;
    m_oy = 1'b0;
  endtask

  task automatic model_step(input bit xv, input bit yv);
    int ix, iy;
    ix = int'(m_lfx) % D;
    iy = int'(m_lfy) % D;
    m_ox = m_bx[ix];
    m_bx[ix] = xv;
    m_oy = m_by[iy];
    m_by[iy] = yv;
    m_lfx = {m_lfx[6:0], ^(m_lfx & 8'hB8)};
    m_lfy = {m_lfy[6:0], ^(m_lfy & 8'hB8)};
  endtask

  function automatic int model_ones(input bit b[D]);
    int n = 0;
    for (int i = 0; i < D; i++) n += int'(b[i]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, let one rising edge pass, compare at the next falling edge.
  task automatic step(input bit e, input bit xv, input bit yv, input string tag);
    bus.en = e;
    bus.x  = xv;
    bus.y  = yv;
    @(negedge clk);
    if (e) begin
      model_step(xv, yv);
      ox_ones += int'(bus.x_dec_r);
      oy_ones += int'(bus.y_dec_r);
    end
    check({tag, "_x"}, 32'(bus.x_dec_r), 32'(m_ox));
    check({tag, "_y"}, 32'(bus.y_dec_r), 32'(m_oy));
  endtask

  // Asserts reset between edges and checks it takes hold without a clock.
  task automatic reset_pulse(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_rst_x"},   32'(bus.x_dec_r), 32'd0);
    check({tag, "_rst_y"},   32'(bus.y_dec_r), 32'd0);
    check({tag, "_rst_lfx"}, 32'(dut.lfx), 32'hA5);
    check({tag, "_rst_buf"}, 32'({dut.bufx, dut.bufy}), 32'b1010_1010);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    ox_ones = 0;
    oy_ones = 0;
  endtask

  initial begin
    bit          exp_x[4];
    bit          exp_y[4];
    bit          stream[256];
    logic [7:0]  held_lfx, held_lfy;
    bit          held_ox, held_oy;
    int          a, b, c, d, ex_x, ex_y;
    real         num, den, scc;
    bit          px, py, tmp;

    bus.en = 1'b0;
    bus.x  = 1'b0;
    bus.y  = 1'b0;
    rst_n  = 1'b1;
    ox_ones = 0;
    oy_ones = 0;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    check("reset_x",    32'(bus.x_dec_r), 32'd0);
    check("reset_y",    32'(bus.y_dec_r), 32'd0);
    check("reset_lfx",  32'(dut.lfx), 32'hA5);
    check("reset_lfy",  32'(dut.lfy), 32'h3C);
    check("reset_bufx", 32'(dut.bufx), 32'b1010);
    check("reset_bufy", 32'(dut.bufy), 32'b1010);

    // Release coinciding with en=1; hand-traced: idx_x 1,2,1,2 and idx_y 0,1,3,3.
    exp_x = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_y = '{1'b0, 1'b1, 1'b1, 1'b1};
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, "directed");
      check("hand_x", 32'(bus.x_dec_r), 32'(exp_x[i]));
      check("hand_y", 32'(bus.y_dec_r), 32'(exp_y[i]));
    end
    check("hand_lfx", 32'(dut.lfx), 32'h54);
    check("hand_lfy", 32'(dut.lfy), 32'hCE);

    // All ones: 256 in + 2 initially held - 4 left behind = 254 out.
    reset_pulse("ones");
    for (int i = 0; i < 256; i++) step(1'b1, 1'b1, 1'b1, "ones");
    check("ones_cnt_x", 32'(ox_ones), 32'd254);
    check("ones_cnt_y", 32'(oy_ones), 32'd254);
    check("ones_bufx", 32'(dut.bufx), 32'hF);
    check("ones_bufy", 32'(dut.bufy), 32'hF);

    // All zeros, including the first post-reset edge reading bufx[1] / bufy[0].
    reset_pulse("zeros");
    step(1'b1, 1'b0, 1'b0, "zeros");
    check("first_x", 32'(bus.x_dec_r), 32'd1);
    check("first_y", 32'(bus.y_dec_r), 32'd0);
    for (int i = 1; i < 256; i++) step(1'b1, 1'b0, 1'b0, "zeros");
    check("zeros_cnt_x", 32'(ox_ones), 32'd2);
    check("zeros_cnt_y", 32'(oy_ones), 32'd2);
    check("zeros_bufx", 32'(dut.bufx), 32'h0);
    check("zeros_bufy", 32'(dut.bufy), 32'h0);

    // Stall: en=0 with toggling inputs must freeze everything.
    reset_pulse("stall");
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "prestall");
    held_lfx = m_lfx;
    held_lfy = m_lfy;
    held_ox  = m_ox;
    held_oy  = m_oy;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'(i % 2), 1'((i + 1) % 2), "stall");
      check("stall_lfx", 32'(dut.lfx), 32'(held_lfx));
      check("stall_lfy", 32'(dut.lfy), 32'(held_lfy));
      check("stall_hold", 32'({bus.x_dec_r, bus.y_dec_r}), 32'({held_ox, held_oy}));
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "resume");

    // Identical inputs: shuffled stream with exactly 128 ones.
    for (int i = 0; i < 256; i++) stream[i] = (i < 128);
    for (int i = 255; i > 0; i--) begin
      int j;
      j = int'($urandom_range(0, i));
      tmp = stream[i];
      stream[i] = stream[j];
      stream[j] = tmp;
    end
    reset_pulse("ident");
    a = 0; b = 0; c = 0; d = 0;
    for (int i = 0; i < 256; i++) begin
      step(1'b1, stream[i], stream[i], "ident");
      px = bus.x_dec_r;
      py = bus.y_dec_r;
      if (px && py) a++;
      else if (px) b++;
      else if (py) c++;
      else d++;
    end
    ex_x = 128 + 2 - model_ones(m_bx);
    ex_y = 128 + 2 - model_ones(m_by);
    check("ident_cons_x", 32'(ox_ones), 32'(ex_x));
    check("ident_cons_y", 32'(oy_ones), 32'(ex_y));
    num = real'(a) * real'(d) - real'(b) * real'(c);
    if (num > 0.0) begin
      den = 256.0 * real'(((a + b) < (a + c)) ? (a + b) : (a + c)) - real'(a + b) * real'(a + c);
    end else begin
      den = real'(a + b) * real'(a + c)
          - 256.0 * real'(((2 * a + b + c - 256) > 0) ? (2 * a + b + c - 256) : 0);
    end
    scc = (den != 0.0) ? num / den : 1.0;
    $display("identical-input output SCC = %f", scc);
    check("ident_scc", 32'((scc < 0.3) && (scc > -0.3)), 32'd1);

    // Random streams at p=0.25 then p=0.75, random enable, one mid-run reset.
    reset_pulse("rand");
    for (int i = 0; i < 1024; i++) begin
      int thr;
      thr = (i < 512) ? 25 : 75;
      if (i == 600) reset_pulse("rand_mid");
      step(1'($urandom_range(0, 99) < 80),
           1'($urandom_range(0, 99) < thr),
           1'($urandom_range(0, 99) < thr), "rand");
    end
    check("rand_lfx", 32'(dut.lfx), 32'(m_lfx));
    check("rand_lfy", 32'(dut.lfy), 32'(m_lfy));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
